// File: rtl/msrv32_imem_slave_if.sv
// Fetch and preload signals between the PC stage (master) and the
// instruction-memory responder (slave).
interface msrv32_imem_slave_if;
    logic        req_in;
    logic [31:0] iaddr_in;
    logic [31:0] instr_out;
    logic        instr_valid_out;
    logic        ahb_ready_out;
    logic        imem_err_out;
    logic        wr_en_in;
    logic [31:0] wr_addr_in;
    logic [31:0] wr_data_in;

    modport slave (
        input  req_in,
        input  iaddr_in,
        input  wr_en_in,
        input  wr_addr_in,
        input  wr_data_in,
        output instr_out,
        output instr_valid_out,
        output ahb_ready_out,
        output imem_err_out
    );

    modport master (
        output req_in,
        output iaddr_in,
        output wr_en_in,
        output wr_addr_in,
        output wr_data_in,
        input  instr_out,
        input  instr_valid_out,
        input  ahb_ready_out,
        input  imem_err_out
    );
endinterface

// File: rtl/msrv32_imem_slave.sv
// Instruction-memory responder: captures a fetch address, stalls for
// WAIT_STATES cycles, then returns one word (or NOP + error) with a one-cycle strobe.
module msrv32_imem_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    msrv32_imem_slave_if.slave   bus
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic [3:0]  wait_cnt_reg;
    logic [3:0]  wait_cnt_next;
    logic [31:0] addr_reg;
    logic [31:0] addr_next;
    logic [31:0] instr_reg;
    logic        err_reg;

    logic        rd_fire;
    logic [31:0] rd_addr;
    logic [32:0] rd_diff;
    logic        rd_err;
    logic [IDX_W-1:0] rd_idx;

    logic [32:0] wr_diff;
    logic        wr_ok;
    logic [IDX_W-1:0] wr_idx;

    logic [31:0] mem [DEPTH_WORDS];

    // 33-bit difference: bit 32 set means the address lies below BASE_ADDR,
    // so no underflow can wrap back into the array window.
    always_comb begin
        rd_diff = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
        rd_err  = (rd_addr[1:0] != 2'b00) || rd_diff[32] || (rd_diff[31:0] >= SPAN_BYTES);
        rd_idx  = rd_diff[IDX_W+1:2];
    end

    always_comb begin
        wr_diff = {1'b0, bus.wr_addr_in} - {1'b0, BASE_ADDR};
        wr_ok   = !wr_diff[32] && (wr_diff[31:0] < SPAN_BYTES);
        wr_idx  = wr_diff[IDX_W+1:2];
    end

    // Next-state logic. IDLE and RESP both accept a new request, which is
    // what makes back-to-back fetches run at one per WAIT_STATES+1 cycles.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        addr_next     = addr_reg;
        rd_fire       = 1'b0;
        rd_addr       = addr_reg;
        case (state_reg)
            ST_WAIT: begin
                wait_cnt_next = wait_cnt_reg - 4'd1;
                if (wait_cnt_reg <= 4'd1) begin
                    rd_fire    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            default: begin
                state_next = ST_IDLE;
                if (bus.req_in) begin
                    addr_next     = bus.iaddr_in;
                    wait_cnt_next = WAIT_LOAD;
                    if (WAIT_STATES == 0) begin
                        // Zero wait states: read straight from the incoming address.
                        rd_fire    = 1'b1;
                        rd_addr    = bus.iaddr_in;
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
            addr_reg     <= 32'd0;
            instr_reg    <= NOP_INSTR;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            addr_reg     <= addr_next;
            if (rd_fire) begin
                err_reg   <= rd_err;
                instr_reg <= rd_err ? NOP_INSTR : mem[rd_idx];
            end
        end
    end

    // Separate write process; the non-blocking update makes a same-cycle
    // read of the same word return the old contents.
    always_ff @(posedge clk_in) begin
        if (bus.wr_en_in && wr_ok) begin
            mem[wr_idx] <= bus.wr_data_in;
        end
    end

    assign bus.instr_out       = instr_reg;
    assign bus.imem_err_out    = err_reg;
    assign bus.instr_valid_out = (state_reg == ST_RESP);
    assign bus.ahb_ready_out   = (state_reg != ST_WAIT);

endmodule

// File: tb/tb_msrv32_imem_slave.sv
// Directed bench: one responder with two wait states and one with none,
// sharing clock, reset and preload data.
module tb_msrv32_imem_slave;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    msrv32_imem_slave_if bus2 ();
    msrv32_imem_slave_if bus0 ();

    msrv32_imem_slave #(
        .DEPTH_WORDS(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0), .NOP_INSTR(NOP)
    ) u_dut_ws2 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus2)
    );

    msrv32_imem_slave #(
        .DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0), .NOP_INSTR(NOP)
    ) u_dut_ws0 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle2(input string tag, input logic [31:0] exp_instr, input logic exp_err);
        check({tag, "_ready"}, 32'(bus2.ahb_ready_out), 32'd1);
        check({tag, "_valid"}, 32'(bus2.instr_valid_out), 32'd0);
        check({tag, "_err"},   32'(bus2.imem_err_out), 32'(exp_err));
        check({tag, "_instr"}, bus2.instr_out, exp_instr);
    endtask

    // Preload one word into both responders; called on a falling edge.
    task automatic wr_word(input logic [31:0] addr, input logic [31:0] data);
        bus2.wr_en_in = 1'b1; bus2.wr_addr_in = addr; bus2.wr_data_in = data;
        bus0.wr_en_in = 1'b1; bus0.wr_addr_in = addr; bus0.wr_data_in = data;
        @(negedge clk);
        bus2.wr_en_in = 1'b0;
        bus0.wr_en_in = 1'b0;
        $display("write addr=%08h data=%08h", addr, data);
    endtask

    // One fetch on the two-wait-state responder. iaddr_in is scrambled during
    // the stall; with collide set, the same word is written on the read edge.
    task automatic fetch2(input logic [31:0] addr, input logic [31:0] exp_instr,
                          input logic exp_err, input bit collide,
                          input logic [31:0] cdata, input string tag);
        bus2.req_in   = 1'b1;
        bus2.iaddr_in = addr;
        @(negedge clk);
        bus2.req_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check({tag, "_stall_ready"}, 32'(bus2.ahb_ready_out), 32'd0);
            check({tag, "_stall_valid"}, 32'(bus2.instr_valid_out), 32'd0);
            bus2.iaddr_in = ~addr;
            if (collide && i == 1) begin
                bus2.wr_en_in   = 1'b1;
                bus2.wr_addr_in = addr;
                bus2.wr_data_in = cdata;
            end
            @(negedge clk);
        end
        bus2.wr_en_in = 1'b0;
        check({tag, "_valid"}, 32'(bus2.instr_valid_out), 32'd1);
        check({tag, "_ready"}, 32'(bus2.ahb_ready_out), 32'd1);
        check({tag, "_instr"}, bus2.instr_out, exp_instr);
        check({tag, "_err"},   32'(bus2.imem_err_out), 32'(exp_err));
        $display("fetch %s addr=%08h instr=%08h err=%0d", tag, addr, bus2.instr_out, bus2.imem_err_out);
        @(negedge clk);
        check_idle2({tag, "_hold"}, exp_instr, exp_err);
    endtask

    logic [31:0] b2b_data [3];

    initial begin
        bus2.req_in = 1'b0; bus2.iaddr_in = 32'h0;
        bus2.wr_en_in = 1'b0; bus2.wr_addr_in = 32'h0; bus2.wr_data_in = 32'h0;
        bus0.req_in = 1'b0; bus0.iaddr_in = 32'h0;
        bus0.wr_en_in = 1'b0; bus0.wr_addr_in = 32'h0; bus0.wr_data_in = 32'h0;
        b2b_data[0] = 32'hA000_0000;
        b2b_data[1] = 32'hA111_1111;
        b2b_data[2] = 32'hA222_2222;

        repeat (2) @(negedge clk);
        check_idle2("reset", NOP, 1'b0);
        check("reset_ws0_instr", bus0.instr_out, NOP);
        rst_n = 1'b1;
        @(negedge clk);

        wr_word(32'h0000_000C, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) wr_word(32'(4 * i), b2b_data[i]);
        wr_word(32'h0000_0014, 32'h5555_0000);
        wr_word(32'h0000_1000, 32'hBAD0_BAD0);

        fetch2(32'h0000_000C, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, "basic");
        fetch2(32'h0000_0000, 32'hA000_0000, 1'b0, 1'b0, 32'h0, "oor_write_dropped");
        fetch2(32'h0000_0006, NOP, 1'b1, 1'b0, 32'h0, "misaligned");
        fetch2(32'h0000_1000, NOP, 1'b1, 1'b0, 32'h0, "out_of_range");
        fetch2(32'hFFFF_FFFC, NOP, 1'b1, 1'b0, 32'h0, "top_addr");
        fetch2(32'h0000_0014, 32'h5555_0000, 1'b0, 1'b1, 32'h6666_0000, "collide_old");
        fetch2(32'h0000_0014, 32'h6666_0000, 1'b0, 1'b0, 32'h0, "collide_new");

        // Zero wait states, request held high: one response per cycle.
        bus0.req_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus0.iaddr_in = 32'(4 * i);
            @(negedge clk);
            check($sformatf("b2b%0d_valid", i), 32'(bus0.instr_valid_out), 32'd1);
            check($sformatf("b2b%0d_ready", i), 32'(bus0.ahb_ready_out), 32'd1);
            check($sformatf("b2b%0d_instr", i), bus0.instr_out, b2b_data[i]);
            check($sformatf("b2b%0d_err", i), 32'(bus0.imem_err_out), 32'd0);
            $display("fetch b2b%0d addr=%08h instr=%08h", i, 32'(4 * i), bus0.instr_out);
        end
        bus0.req_in = 1'b0;
        @(negedge clk);
        check("b2b_end_valid", 32'(bus0.instr_valid_out), 32'd0);
        check("b2b_end_instr", bus0.instr_out, b2b_data[2]);

        // Reset in the middle of a stall aborts the fetch.
        fetch2(32'h0000_0006, NOP, 1'b1, 1'b0, 32'h0, "pre_reset_err");
        bus2.req_in   = 1'b1;
        bus2.iaddr_in = 32'h0000_000C;
        @(negedge clk);
        bus2.req_in = 1'b0;
        check("mid_wait_ready", 32'(bus2.ahb_ready_out), 32'd0);
        rst_n = 1'b0;
        #1;
        check_idle2("async_reset", NOP, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_idle2("reset_held", NOP, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle2("post_release", NOP, 1'b0);
        fetch2(32'h0000_000C, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
